// File: rtl/chess_layout_matrix_pkg.sv
// Shared board encoding for the chess layout block: field positions, piece and
// select codes, and the power-on board with the cursor on square 60.
package chess_pkg;

    localparam int SQUARE_WIDTH  = 8;
    localparam int CHESS_SQUARES = 64;
    localparam int LAYOUT_WIDTH  = SQUARE_WIDTH * CHESS_SQUARES;

    typedef enum logic [2:0] {
        PIECE_EMPTY    = 3'd0,
        PIECE_KING     = 3'd1,
        PIECE_QUEEN    = 3'd2,
        PIECE_ROOK     = 3'd3,
        PIECE_BISHOP   = 3'd4,
        PIECE_KNIGHT   = 3'd5,
        PIECE_PAWN     = 3'd6,
        PIECE_RESERVED = 3'd7
    } piece_e;

    typedef enum logic [1:0] {
        SEL_NONE       = 2'd0,
        SEL_PRESELECT  = 2'd1,
        SEL_SELECT     = 2'd2,
        SEL_POSTSELECT = 2'd3
    } select_e;

    typedef enum logic [1:0] {
        KEY_LEFT  = 2'd0,
        KEY_UP    = 2'd1,
        KEY_DOWN  = 2'd2,
        KEY_RIGHT = 2'd3
    } key_e;

    localparam logic COLOUR_DARK  = 1'b0;
    localparam logic COLOUR_LIGHT = 1'b1;

    localparam int PIECE_LSB  = 0;
    localparam int PIECE_MSB  = 2;
    localparam int COLOUR_BIT = 3;
    localparam int SELECT_LSB = 4;
    localparam int SELECT_MSB = 5;

    localparam logic [2:0] CURSOR_RESET_ROW = 3'd7;
    localparam logic [2:0] CURSOR_RESET_COL = 3'd4;

    // Most significant row first; within a row col 7 is the leftmost byte.
    localparam logic [LAYOUT_WIDTH-1:0] RESET_LAYOUT = {
        64'h0B0D_0C19_0A0C_0D0B,
        64'h0E0E_0E0E_0E0E_0E0E,
        64'h0000_0000_0000_0000,
        64'h0000_0000_0000_0000,
        64'h0000_0000_0000_0000,
        64'h0000_0000_0000_0000,
        64'h0606_0606_0606_0606,
        64'h0305_0401_0204_0503
    };

    function automatic logic [5:0] square_index(input logic [2:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/chess_layout_matrix_if.sv
// Key inputs and board output of the chess layout block, bundled for the
// key driver (master) and the board-state logic (slave).
interface chess_layout_matrix_if;
    import chess_pkg::*;

    logic                    KeyLeft;
    logic                    KeyUp;
    logic                    KeyDown;
    logic                    KeyRight;
    logic [LAYOUT_WIDTH-1:0] Layout;

    modport master (
        output KeyLeft,
        output KeyUp,
        output KeyDown,
        output KeyRight,
        input  Layout
    );

    modport slave (
        input  KeyLeft,
        input  KeyUp,
        input  KeyDown,
        input  KeyRight,
        output Layout
    );

endinterface

// File: rtl/chess_layout_matrix_key_debounce.sv
// One push-button: 2-FF synchronizer, stability counter and a single-cycle
// pulse on each accepted press (debounced high-to-low change).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic srst,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [1:0]    sync_reg;
    logic          stable_reg;
    logic [CW-1:0] count_reg;
    logic [1:0]    flush_reg;
    logic          armed_reg;
    logic          press_reg;

    logic sync_key;
    logic settle_done;

    assign sync_key    = sync_reg[1];
    assign settle_done = (count_reg == CW'(DEBOUNCE_CYCLES - 1));
    assign press       = press_reg;

    // The synchronizer holds its reset value for two edges, so the arm flag
    // only trusts sync_key once it reflects a real post-reset sample. A key
    // held through reset therefore has to be seen released before it fires.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg   <= 2'b11;
            stable_reg <= 1'b1;
            count_reg  <= '0;
            flush_reg  <= 2'd0;
            armed_reg  <= 1'b0;
            press_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], key_n};
            press_reg <= 1'b0;

            if (flush_reg != 2'd2) begin
                flush_reg <= flush_reg + 2'd1;
            end else if (sync_key) begin
                armed_reg <= 1'b1;
            end

            if (sync_key != stable_reg) begin
                if (settle_done) begin
                    stable_reg <= sync_key;
                    count_reg  <= '0;
                    press_reg  <= !sync_key && armed_reg;
                end else begin
                    count_reg <= count_reg + 1'b1;
                end
            end else begin
                count_reg <= '0;
            end
        end
    end

endmodule

// File: rtl/chess_layout_matrix.sv
// Board state for the chess game: debounces the four keys, moves the
// pre-select cursor with edge saturation and keeps the 64-square Layout.
module chess_layout_matrix
    import chess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clock,
    input  logic                 resetApp,
    chess_layout_matrix_if.slave bus
);

    logic [3:0]              key_n;
    logic [3:0]              press;
    logic                    single_press;
    logic [2:0]              row_reg;
    logic [2:0]              col_reg;
    logic [2:0]              row_next;
    logic [2:0]              col_next;
    logic [5:0]              cursor_next;
    logic                    move;
    logic [LAYOUT_WIDTH-1:0] layout_flat;

    assign key_n[KEY_LEFT]  = bus.KeyLeft;
    assign key_n[KEY_UP]    = bus.KeyUp;
    assign key_n[KEY_DOWN]  = bus.KeyDown;
    assign key_n[KEY_RIGHT] = bus.KeyRight;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gen_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key (
                .clk   (clock),
                .srst  (resetApp),
                .key_n (key_n[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    // Two or more simultaneous pulses are treated as an ambiguous chord.
    assign single_press = (press != 4'b0000) && ((press & (press - 4'd1)) == 4'b0000);

    always_comb begin
        row_next = row_reg;
        col_next = col_reg;
        if (single_press) begin
            if (press[KEY_LEFT] && col_reg != 3'd0) begin
                col_next = col_reg - 3'd1;
            end
            if (press[KEY_RIGHT] && col_reg != 3'd7) begin
                col_next = col_reg + 3'd1;
            end
            if (press[KEY_UP] && row_reg != 3'd0) begin
                row_next = row_reg - 3'd1;
            end
            if (press[KEY_DOWN] && row_reg != 3'd7) begin
                row_next = row_reg + 3'd1;
            end
        end
    end

    assign cursor_next = square_index(row_next, col_next);
    assign move        = (cursor_next != square_index(row_reg, col_reg));

    always_ff @(posedge clock) begin
        if (resetApp) begin
            row_reg <= CURSOR_RESET_ROW;
            col_reg <= CURSOR_RESET_COL;
        end else if (move) begin
            row_reg <= row_next;
            col_reg <= col_next;
        end
    end

    // Each square owns its byte; only the select field is ever rewritten.
    generate
        for (gi = 0; gi < CHESS_SQUARES; gi++) begin : gen_square
            logic [SQUARE_WIDTH-1:0] square_reg;

            always_ff @(posedge clock) begin
                if (resetApp) begin
                    square_reg <= RESET_LAYOUT[gi*SQUARE_WIDTH +: SQUARE_WIDTH];
                end else if (move) begin
                    square_reg[SELECT_MSB:SELECT_LSB] <=
                        (cursor_next == 6'(gi)) ? SEL_PRESELECT : SEL_NONE;
                end
            end

            assign layout_flat[gi*SQUARE_WIDTH +: SQUARE_WIDTH] = square_reg;
        end
    endgenerate

    assign bus.Layout = layout_flat;

endmodule

// File: tb/tb_chess_layout_matrix.sv
// Directed bench for chess_layout_matrix: a board model predicts Layout after
// each stimulus step, the prediction is queued and compared when due.
module tb_chess_layout_matrix;
    import chess_pkg::*;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       resetApp;
    logic [3:0] keys_n;

    always #5 clock = ~clock;

    chess_layout_matrix_if bus ();

    assign bus.KeyLeft  = keys_n[0];
    assign bus.KeyUp    = keys_n[1];
    assign bus.KeyDown  = keys_n[2];
    assign bus.KeyRight = keys_n[3];

    chess_layout_matrix #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock    (clock),
        .resetApp (resetApp),
        .bus      (bus)
    );

    int           n_asserts = 0;
    int           n_fails   = 0;
    logic [511:0] exp_q[$];
    int           exp_row;
    int           exp_col;

    function automatic logic [511:0] model_layout(input int crow, input int ccol);
        int           back[8];
        logic [511:0] v;
        logic [7:0]   b;
        back = '{3, 5, 4, 2, 1, 4, 5, 3};
        v = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                b = 8'h00;
                if (r == 0) b = 8'(back[c]);
                if (r == 1) b = 8'h06;
                if (r == 6) b = 8'h0E;
                if (r == 7) b = 8'h08 | 8'(back[c]);
                if (r == crow && c == ccol) b = b | 8'h10;
                v[(r*8+c)*8 +: 8] = b;
            end
        end
        return v;
    endfunction

    task automatic model_press(input int k);
        case (k)
            0: if (exp_col > 0) exp_col--;
            1: if (exp_row > 0) exp_row--;
            2: if (exp_row < 7) exp_row++;
            default: if (exp_col < 7) exp_col++;
        endcase
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_expected();
        exp_q.push_back(model_layout(exp_row, exp_col));
    endtask

    task automatic check_layout(input string tag, input int wait_cycles);
        logic [511:0] exp;
        tick(wait_cycles);
        exp = exp_q.pop_front();
        n_asserts++;
        assert (bus.Layout === exp) else begin
            n_fails++;
            $error("FAIL %s: Layout observed %h expected %h", tag, bus.Layout, exp);
        end
    endtask

    task automatic check_byte(input string tag, input int idx, input logic [7:0] exp);
        n_asserts++;
        assert (bus.Layout[idx*8 +: 8] === exp) else begin
            n_fails++;
            $error("FAIL %s: byte%0d observed %h expected %h", tag, idx, bus.Layout[idx*8 +: 8], exp);
        end
    endtask

    task automatic check_one_cursor(input string tag);
        int sel_count;
        sel_count = 0;
        for (int i = 0; i < 64; i++) begin
            if (bus.Layout[i*8+4 +: 2] != 2'b00) sel_count++;
        end
        n_asserts++;
        assert (sel_count === 1) else begin
            n_fails++;
            $error("FAIL %s: select fields set observed %0d expected 1", tag, sel_count);
        end
    endtask

    task automatic press(input int k);
        keys_n[k] = 1'b0;
        tick(10);
        keys_n[k] = 1'b1;
        tick(10);
        model_press(k);
    endtask

    task automatic do_reset(input string tag);
        resetApp = 1'b1;
        tick(1);
        resetApp = 1'b0;
        exp_row = 7;
        exp_col = 4;
        push_expected();
        check_layout(tag, 0);
        tick(3);
    endtask

    initial begin
        keys_n   = 4'hF;
        resetApp = 1'b1;
        exp_row  = 7;
        exp_col  = 4;
        tick(3);
        resetApp = 1'b0;

        // Reset contents
        push_expected();
        check_layout("reset_layout", 1);
        check_byte("reset_b0", 0, 8'h03);
        check_byte("reset_b4", 4, 8'h01);
        check_byte("reset_b8", 8, 8'h06);
        check_byte("reset_b20", 20, 8'h00);
        check_byte("reset_b48", 48, 8'h0E);
        check_byte("reset_b60", 60, 8'h19);
        check_byte("reset_b63", 63, 8'h0B);
        check_one_cursor("reset_cursor");
        tick(3);

        // Held Up key moves once
        keys_n[1] = 1'b0;
        model_press(1);
        push_expected();
        check_layout("up_move", 8);
        check_byte("up_b60", 60, 8'h09);
        check_byte("up_b52", 52, 8'h1E);
        push_expected();
        check_layout("up_hold", 2);
        keys_n[1] = 1'b1;
        tick(10);

        // Left saturation from square 60
        do_reset("reset_before_left");
        for (int i = 0; i < 5; i++) begin
            press(0);
            push_expected();
            check_layout($sformatf("left_%0d", i), 0);
        end
        check_byte("left_b56", 56, 8'h1B);
        check_byte("left_b60", 60, 8'h09);

        // Short glitches on Right
        for (int i = 0; i < 3; i++) begin
            keys_n[3] = 1'b0;
            tick(2);
            keys_n[3] = 1'b1;
            tick(1);
        end
        push_expected();
        check_layout("right_glitch", 10);

        // Up+Down chord is ignored
        keys_n[1] = 1'b0;
        keys_n[2] = 1'b0;
        push_expected();
        check_layout("updown_chord", 12);
        keys_n[1] = 1'b1;
        keys_n[2] = 1'b1;
        tick(10);

        for (int i = 0; i < 7; i++) press(1);
        push_expected();
        check_layout("row0", 0);
        press(1);
        push_expected();
        check_layout("up_saturated", 0);
        check_one_cursor("row0_cursor");

        // Key held across reset must not fire until re-pressed
        keys_n[0] = 1'b0;
        do_reset("reset_key_held");
        push_expected();
        check_layout("held_through_reset", 12);
        keys_n[0] = 1'b1;
        tick(10);
        press(0);
        push_expected();
        check_layout("left_after_rearm", 0);

        // Move to square 35 then reset
        for (int i = 0; i < 3; i++) press(1);
        push_expected();
        check_layout("at_35", 0);
        check_byte("b35_cursor", 35, 8'h10);
        do_reset("reset_from_35");
        check_byte("b35_after_reset", 35, 8'h00);
        check_byte("b60_after_reset", 60, 8'h19);
        check_one_cursor("final_cursor");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
